// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, DATA_BITS LSB-first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tx_start_i,
  input  logic [DATA_BITS-1:0] tx_din_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_tick_o
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d is the level of the bit being entered, so tx_o flips on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = 16'd0;
        idx_d  = '0;
        if (tx_start_i) begin
          state_d = START;
          shift_d = tx_din_i;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_din_i;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 16'd0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Done is registered: it rises on the edge that enters the last STOP cycle.
  assign done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_o           = tx_q;
  assign tx_busy_o      = busy_q;
  assign tx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CLKS = 10;
  localparam int DB   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 2 + DB + PB;
  localparam int FRAME = NBITS * CLKS;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          tx_start_i = 1'b0;
  logic [DB-1:0] tx_din_i = '0;
  logic          tx_o, tx_busy_o, tx_done_tick_o;

  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DB)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .tx_start_i     (tx_start_i),
    .tx_din_i       (tx_din_i),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy_o),
    .tx_done_tick_o (tx_done_tick_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_level(input logic [DB-1:0] v, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return v[b-1];
    if (PB == 1 && b == DB + 1) return ^v;
    return 1'b1;
  endfunction

  // Drives a start at a negedge; returns at the negedge of frame cycle 1.
  task automatic send(input logic [DB-1:0] v, input bit hold);
    @(negedge clk);
    tx_din_i   = v;
    tx_start_i = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    if (!hold) begin
      tx_start_i = 1'b0;
      tx_din_i   = ~v;
    end
  endtask

  task automatic check_frame(input int inject_at);
    logic [DB-1:0] v;
    int match[NBITS];
    int busy_cnt, done_cnt, done_pos, b;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", exp_q.size(), 1);
      return;
    end
    v = exp_q.pop_front();
    busy_cnt = 0; done_cnt = 0; done_pos = 0;
    for (int i = 0; i < NBITS; i++) match[i] = 0;
    for (int k = 1; k <= FRAME; k++) begin
      b = (k - 1) / CLKS;
      if (tx_o === exp_level(v, b)) match[b]++;
      if (tx_busy_o === 1'b1) busy_cnt++;
      if (tx_done_tick_o === 1'b1) begin
        done_cnt++;
        done_pos = k;
      end
      if (inject_at > 0 && k == inject_at) begin
        tx_din_i   = 8'h55;
        tx_start_i = 1'b1;
      end else if (inject_at > 0 && k == inject_at + 1) begin
        tx_start_i = 1'b0;
      end
      if (k < FRAME) @(negedge clk);
    end
    for (int i = 0; i < NBITS; i++)
      chk($sformatf("bit%0d_of_%02h", i, v), match[i], CLKS);
    chk($sformatf("busy_cycles_%02h", v), busy_cnt, FRAME);
    chk($sformatf("done_count_%02h", v), done_cnt, 1);
    chk($sformatf("done_pos_%02h", v), done_pos, FRAME);
  endtask

  task automatic idle_check(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_o === 1'b1 && tx_busy_o === 1'b0 && tx_done_tick_o === 1'b0) cnt++;
    end
    chk(tag, cnt, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_o), 1);
    chk("rst_busy", int'(tx_busy_o), 0);
    chk("rst_done", int'(tx_done_tick_o), 0);
    rstn_i = 1'b1;
    idle_check("post_rst_idle", 3);

    send(8'hAB, 1'b0);
    check_frame(0);
    idle_check("idle_after_ab", 5);

    send(8'hAB, 1'b0);
    check_frame(30);
    idle_check("no_extra_frame", 2 * FRAME);
    chk("sb_empty_after_inject", exp_q.size(), 0);

    foreach (tx_din_i[i]) begin end
    begin
      logic [DB-1:0] pats[6];
      pats = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E, 8'h00};
      pats[5] = DB'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++) begin
        send(pats[i], 1'b0);
        check_frame(0);
        idle_check($sformatf("gap_%0d", i), 2);
      end
    end

    send(8'h3C, 1'b1);
    for (int f = 0; f < 3; f++) begin
      check_frame(0);
      @(negedge clk);
      chk($sformatf("b2b_gap_tx_%0d", f), int'(tx_o), 1);
      chk($sformatf("b2b_gap_busy_%0d", f), int'(tx_busy_o), 0);
      if (f < 2) begin
        exp_q.push_back(8'h3C);
        @(negedge clk);
        chk($sformatf("b2b_start_%0d", f), int'(tx_o), 0);
        if (f == 1) tx_start_i = 1'b0;
      end
    end
    idle_check("b2b_no_fourth", 2 * FRAME);

    @(negedge clk);
    tx_din_i   = 8'hAB;
    tx_start_i = 1'b1;
    @(negedge clk);
    tx_start_i = 1'b0;
    repeat (44) @(negedge clk);
    rstn_i     = 1'b0;
    tx_start_i = 1'b1;
    @(negedge clk);
    chk("abort_tx", int'(tx_o), 1);
    chk("abort_busy", int'(tx_busy_o), 0);
    chk("abort_done", int'(tx_done_tick_o), 0);
    rstn_i     = 1'b1;
    tx_start_i = 1'b0;
    idle_check("abort_quiet", FRAME + 10);

    send(8'hC5, 1'b0);
    check_frame(0);
    idle_check("final_idle", 4);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period (legal range 2..65535).
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame (legal range 5..8).
REQ-003 Port clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 Port rstn_i  input  1  reset; synchronous and active-low.
REQ-005 Port tx_start_i  input  1  request to send tx_din_i; honoured only in IDLE.
REQ-006 Port tx_din_i  input  DATA_BITS  payload; sampled on the accepting edge only.
REQ-007 Port tx_o  output  1  serial line; idle-high, registered.
REQ-008 Port tx_busy_o  output  1  high while a frame is in progress.
REQ-009 Port tx_done_tick_o  output  1  one-cycle pulse at end of frame.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN), STOP.
REQ-011 In IDLE with tx_start_i=1 at a rising edge, the block SHALL latch tx_din_i into a shift register and enter START.
REQ-012 tx_o SHALL be 0 from the edge entering START for exactly CLKS_PER_BIT cycles.
REQ-013 DATA SHALL drive DATA_BITS bits, LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-014 STOP SHALL drive tx_o=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-015 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; bit index counter SHALL be $clog2(DATA_BITS) wide minimum.
REQ-016 tx_busy_o SHALL be 1 from the accepting edge through the last STOP cycle, and 0 in IDLE.
REQ-017 tx_done_tick_o SHALL be 1 for exactly the final clock cycle of STOP; 0 otherwise.
REQ-018 tx_start_i while busy SHALL be ignored; no queuing; tx_din_i changes mid-frame SHALL NOT affect the frame.
REQ-019 tx_start_i held high continuously SHALL produce back-to-back frames: the next frame is accepted on the first IDLE cycle after tx_done_tick_o, giving one idle-high cycle between frames.
REQ-020 Frame length from accepting edge to return to IDLE SHALL be (2+DATA_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
REQ-021 tx_o SHALL be glitch-free (driven from a flop, not from FSM decode).

Reset
REQ-022 With rstn_i=0 at a rising edge: state=IDLE, counters=0, shift register=0, tx_o=1, tx_busy_o=0, tx_done_tick_o=0.
REQ-023 Reset mid-frame SHALL abort the frame, with tx_o returning to 1 at that edge and no tx_done_tick_o pulse.
REQ-024 tx_start_i SHALL be ignored on any edge where rstn_i=0.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: a PARITY state SHALL follow DATA for CLKS_PER_BIT cycles, driving even parity (XOR of all data bits).
REQ-026 Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic SHALL exist, and DATA SHALL go directly to STOP.

Verification
REQ-027 Reset, then tx_din_i=0xAB with a 1-cycle tx_start_i (defaults, no parity) -> tx_o = 0,1,1,0,1,0,1,0,1,1, each for 10 cycles; tx_done_tick_o pulses at cycle 100; tx_busy_o high for cycles 1..100.
REQ-028 Same stimulus with UART_TX_PARITY_EN -> parity bit 1 inserted after bit 7; frame length 110 cycles; done tick at cycle 110.
REQ-029 tx_din_i=0x00 with parity -> parity bit 0; tx_din_i=0xFF -> parity bit 0; tx_din_i=0x01 -> parity bit 1.
REQ-030 tx_start_i pulsed with 0x55 at cycle 30 of an active 0xAB frame -> ignored; line carries only 0xAB; no extra frame.
REQ-031 tx_start_i held high with 0x3C -> consecutive frames separated by exactly one idle-high cycle; one tx_done_tick_o per frame.
REQ-032 rstn_i low for 1 cycle at cycle 45 of a frame -> tx_o=1 and tx_busy_o=0 from that edge, no done tick, and a new start afterwards sends a correct frame.
